// File: rtl/timer_ctl.sv
// System-timer controller: generates the periodic zegar tick with a selectable
// 2/4/8/10/20 ms period and manages the CPU interrupt and the lost-tick count.
module timer_ctl #(
   parameter int         CLK_SYS_HZ  = 50_000_000,
   parameter logic [2:0] DEFAULT_SEL = 3'd3
) (
   input  logic       clk_sys,
   input  logic       rst,
   input  logic       enable,
   input  logic       cfg_we,
   input  logic [2:0] cfg_sel,
   output logic       cfg_err,
   output logic [2:0] sel,
   output logic       zegar,
   output logic       irq,
   input  logic       irq_ack,
   output logic [3:0] lost
);

   localparam int            P       = CLK_SYS_HZ / 1000;
   localparam int            PW      = $clog2(P);
   localparam logic [PW-1:0] PRE_MAX = PW'(P - 1);

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      PENDING
   } state_t;

   state_t        state;
   logic [PW-1:0] pre_cnt;
   logic [4:0]    ms_cnt;
   logic          terminal;
   logic          valid_wr;
   logic          bad_wr;

   // Reload value of the ms counter (period_ms - 1) for a period code.
   function automatic logic [4:0] period_max(input logic [2:0] code);
      logic [4:0] m;
      case (code)
         3'd0:    m = 5'd1;
         3'd1:    m = 5'd3;
         3'd2:    m = 5'd7;
         3'd3:    m = 5'd9;
         default: m = 5'd19;
      endcase
      return m;
   endfunction

   assign valid_wr = cfg_we && (cfg_sel <= 3'd4);
   assign bad_wr   = cfg_we && (cfg_sel > 3'd4);
   assign terminal = (pre_cnt == '0) && (ms_cnt == '0);
   // A valid write restarts the period, so a terminal in that cycle is dropped.
   assign zegar    = enable && terminal && !valid_wr;

   always_ff @(posedge clk_sys) begin
      if (rst) begin
         sel     <= DEFAULT_SEL;
         pre_cnt <= PRE_MAX;
         ms_cnt  <= period_max(DEFAULT_SEL);
         cfg_err <= 1'b0;
      end else begin
         cfg_err <= bad_wr;
         if (valid_wr) begin
            sel     <= cfg_sel;
            pre_cnt <= PRE_MAX;
            ms_cnt  <= period_max(cfg_sel);
         end else if (pre_cnt == '0) begin
            pre_cnt <= PRE_MAX;
            ms_cnt  <= (ms_cnt == '0) ? period_max(sel) : ms_cnt - 5'd1;
         end else begin
            pre_cnt <= pre_cnt - PW'(1);
         end
      end
   end

   // Ack takes priority over counting a lost tick; a tick in the ack cycle
   // immediately re-raises the interrupt.
   always_ff @(posedge clk_sys) begin
      if (rst || !enable) begin
         state <= IDLE;
         irq   <= 1'b0;
         lost  <= 4'd0;
      end else begin
         case (state)
            IDLE: begin
               if (zegar) begin
                  state <= PENDING;
                  irq   <= 1'b1;
               end else begin
                  state <= ARMED;
               end
            end
            ARMED: begin
               if (zegar) begin
                  state <= PENDING;
                  irq   <= 1'b1;
               end
            end
            PENDING: begin
               if (irq_ack) begin
                  lost <= 4'd0;
                  if (!zegar) begin
                     state <= ARMED;
                     irq   <= 1'b0;
                  end
               end else if (zegar && (lost != 4'hF)) begin
                  lost <= lost + 4'd1;
               end
            end
            default: begin
               state <= IDLE;
               irq   <= 1'b0;
               lost  <= 4'd0;
            end
         endcase
      end
   end

endmodule

// File: doc/timer_ctl.md
Name: timer_ctl

Overview:
- Control-panel system-timer controller: generates the periodic "zegar" tick with a run-time selectable period, and manages the resulting interrupt request to the CPU.
- Replaces the fixed-period timer with a configurable one. Period is chosen from the five panel settings (2/4/8/10/20 ms).
- Tracks ticks lost while an interrupt is still pending.
- Sits between the control panel (enable, period write) and the CPU interrupt logic (irq/irq_ack).

Parameters:
- CLK_SYS_HZ, 50_000_000, system clock frequency; ms prescale P = CLK_SYS_HZ/1000. P must be ≥ 2.
- DEFAULT_SEL, 3, period selection loaded at reset (3 = 10 ms).

Ports:
- clk_sys  in  1  system clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  panel timer enable
- cfg_we  in  1  one-cycle period-write strobe
- cfg_sel  in  3  period code: 0=2 ms, 1=4 ms, 2=8 ms, 3=10 ms, 4=20 ms; codes 5–7 are invalid
- cfg_err  out  1  one-cycle pulse when a write carries an invalid code
- sel  out  3  currently active period code
- zegar  out  1  one-cycle tick pulse, gated by enable
- irq  out  1  timer interrupt request, level
- irq_ack  in  1  interrupt acknowledge strobe
- lost  out  4  saturating count of ticks that occurred while irq was already set

Behaviour:
- Reset (synchronous): sel=DEFAULT_SEL, irq=0, lost=0, zegar=0, cfg_err=0, state=IDLE. Prescaler loads P-1; ms counter loads period_ms-1.
- Counting:
  - Prescaler down-counts clk_sys and wraps to P-1 at 0.
  - ms counter decrements when the prescaler is 0, and wraps to period_ms-1 at 0.
  - Terminal = prescaler==0 && ms==0. Terminal occurs every T = P*period_ms cycles.
  - Both counters free-run regardless of enable.
- Tick timing: first terminal falls at cycle T-1, where cycle 0 is the first cycle with rst low.
- zegar = enable && terminal, combinational from registers, exactly one cycle wide.
- Valid write (cfg_we && cfg_sel≤4):
  - sel updates at the next edge and both counters reload from the new code.
  - Next terminal falls T_new-1 cycles after the write-following cycle, i.e. a write restarts the period.
  - A terminal coinciding with the write cycle is suppressed (no zegar, no irq effect).
- Invalid write (cfg_we && cfg_sel≥5): sel and counters unchanged; cfg_err=1 for the next cycle only.
- State machine (registered):
  - IDLE (enable=0, irq=0) → ARMED when enable=1.
  - ARMED → PENDING on zegar: irq=1 from the next cycle.
  - PENDING → ARMED on irq_ack: irq=0 and lost=0 from the next cycle.
  - Any state → IDLE when enable=0: irq and lost cleared next cycle.
- irq_ack while irq=0: ignored.
- Tick in PENDING without ack: irq stays 1; lost increments, saturating at 15.
- Tick and irq_ack in the same cycle (in PENDING): ack clears lost to 0, the new tick re-sets irq, so irq remains 1 and lost=0.
- Enable falling on a terminal cycle: zegar=0 for that cycle (gated), so irq is not set.
- rst mid-period: all state returns to reset values on the next edge and counting restarts as after reset.

Test Plan (CLK_SYS_HZ=4000, so P=4):
- Reset, then enable=1, default sel=3 (T=40) → zegar pulses at cycles 39, 79, 119; irq rises at cycle 40.
- Write cfg_sel=0 at cycle 10 → sel=0 at cycle 11; next zegar at cycle 18 (=11+8-1), then every 8 cycles; no zegar at cycle 39.
- Write cfg_sel=6 → cfg_err pulses one cycle; sel stays 3; zegar period unchanged at 40.
- With sel=0, never ack for 20 ticks → irq held at 1; lost counts 1..15 and stays at 15.
- irq_ack asserted on a zegar cycle while irq=1 → irq stays 1, lost=0.
- enable=0 during PENDING → irq=0 and lost=0 next cycle; zegar stays low while the counters keep running; re-enabling yields the next zegar on the original phase.
